instr_ctrl_fsm: RTL and testbench
=================================

// Module: instr_ctrl_fsm
// PURPOSE
//  Decode side of the processor ISA: accepts 9-bit instructions from fetch over valid/ready.
//  Emits registered control words: ALU op, register selects, immediate, write enable,
//  memory request, branch/jump/call/ret. Sits between fetch and the regfile/ALU/data memory.
//  Sequences multi-cycle LOAD/STORE and tracks call depth.
// PARAMETERS
//  CALL_DEPTH   4   max outstanding CALLs before overflow (1..15)
//  MEM_TIMEOUT  15  cycles waited for mem_ack before abort (1..255)
// PORTS
//  CLK          in   1  clock, all state on rising edge
//  reset        in   1  synchronous, active-high
//  instr_i      in   9  instruction; opcode = instr_i[8:4]
//  instr_valid  in   1  instr_i valid
//  instr_ready  out  1  block can accept; transfer when valid&&ready
//  mem_ack      in   1  data memory completed current request
//  ctrl_valid   out  1  control outputs below meaningful this cycle
//  alu_op       out  3  ADD 000, SUB 001, SHR 010, SHL 011, AND 100, OR 101, XOR 110, PASS 111
//  reg_dst      out  3  destination reg (A 000, B 001, C 010, D 011, PC 100)
//  reg_src      out  3  source reg, same encoding
//  imm          out  5  immediate/offset, raw field, zero-extended
//  use_imm      out  1  ALU operand B = imm
//  reg_we       out  1  write reg_dst this cycle
//  mem_rd       out  1  load request, held until ack/timeout
//  mem_wr       out  1  store request, held until ack/timeout
//  br_eqz/br_neqz/jump/call/ret out 1 each  PC-control strobes
//  stack_err    out  1  sticky: CALL at full or RET at empty
//  mem_err      out  1  sticky: memory timeout
// BEHAVIOUR
//  Reset: state=IDLE, depth=0, all outputs 0 except instr_ready=1; errors cleared.
//  All control outputs registered; 0 whenever ctrl_valid=0 (mem_rd/mem_wr excepted, see MEM).
//  Field decode (5-bit exact ops ADDR,SUBR,AND,OR,LOAD,STORE): dst=instr[3:2], src=instr[1:0].
//  4-bit-class ops: ADDI,SUBI,SHR,SHL,ANDI -> dst=instr[4:3], imm=instr[2:0], use_imm=1, we=1.
//   XOR,RSHL: dst=instr[4:3], src=instr[2:1], we=1 (RSHL alu_op=SHL). MOV: dst=instr[4:3], src=instr[2:0], PASS, we=1.
//   BEQZ/BNEQZ: src=instr[4:3], imm=instr[2:0] (3-bit signed offset), PASS, we=0.
//   J/CALL: imm=instr[4:0] (5-bit signed offset), PASS. RET: no operands.
//  ADDR/SUBR/AND/OR: we=1, use_imm=0. Unused bits in a field drive 0.
//  FSM IDLE: instr_ready=1; on valid&&ready latch instr -> EXEC.
//  EXEC (1 cycle): ctrl_valid=1 with decoded word. ALU/branch/jump ops -> IDLE.
//   LOAD/STORE -> MEM; mem_rd/mem_wr rise this cycle. Latency: accept edge N, ctrl_valid cycle N+1.
//  MEM: mem_rd/mem_wr held, ctrl_valid=0; cycle counter from 0.
//   mem_ack: LOAD -> one cycle ctrl_valid=1, reg_we=1, reg_dst=latched dst; STORE -> no pulse; -> IDLE.
//   counter reaches MEM_TIMEOUT w/o ack: drop request, set mem_err, no reg_we -> IDLE.
//   mem_ack coincident with final timeout cycle counts as ack.
//  Throughput: ALU op every 2 cycles; instr_ready=0 in EXEC/MEM.
//  Call depth: CALL at EXEC depth+1; depth==CALL_DEPTH: set stack_err, depth held, call still strobed.
//   RET at depth 0: set stack_err, depth stays 0, ret still strobed.
//  Errors cleared only by reset. Reset mid-MEM drops request same edge; depth->0.
//  mem_ack outside MEM ignored. instr_valid outside IDLE ignored (not consumed).
// TESTING
//  9'b00000_0110 (ADDR D?=B) -> cycle after accept: ctrl_valid=1, alu_op=000, dst=001, src=010, we=1.
//  9'b0001_1_1_101 (ADDI) -> alu_op=000, dst=011, imm=5, use_imm=1, we=1; ready back next cycle.
//  LOAD 9'b10110_1000, ack after 3 cycles -> mem_rd high 4 cycles, then 1 pulse reg_we, dst=010.
//  STORE, no ack -> mem_wr high MEM_TIMEOUT+1 cycles, drops, mem_err=1, no reg_we.
//  5 CALLs (CALL_DEPTH=4) -> 5th sets stack_err; 5 RETs then 1 more keep depth 0.
//  reset asserted in MEM of LOAD -> next cycle mem_rd=0, instr_ready=1, errors 0.

Source files
------------

// File: rtl/instr_ctrl_fsm.sv
// instr_ctrl_fsm: decode/sequence stage between instruction fetch and the
// regfile/ALU/data memory. Takes one 9-bit instruction over valid/ready, emits
// a registered control word, sequences LOAD/STORE handshakes with a timeout
// and tracks CALL/RET nesting depth.
//
// Opcode map on instr_i[8:4] ('x' = low bit belongs to an operand field):
//   00000 ADDR   00001 SUBR   0001x ADDI   0010x SUBI   0011x SHR
//   0100x SHL    0101x ANDI   0110x XOR    0111x RSHL   1000x MOV
//   1001x BEQZ   1010x BNEQZ  10110 LOAD   10111 STORE  11000 AND
//   11001 OR     1101x J      1110x CALL   1111x RET
module instr_ctrl_fsm #(
    parameter int CALL_DEPTH  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [8:0] instr_i,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       mem_ack,
    output logic       ctrl_valid,
    output logic [2:0] alu_op,
    output logic [2:0] reg_dst,
    output logic [2:0] reg_src,
    output logic [4:0] imm,
    output logic       use_imm,
    output logic       reg_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       br_eqz,
    output logic       br_neqz,
    output logic       jump,
    output logic       call,
    output logic       ret,
    output logic       stack_err,
    output logic       mem_err
);
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SHR  = 3'b010;
    localparam logic [2:0] ALU_SHL  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [3:0] DEPTH_MAX = 4'(CALL_DEPTH);
    localparam logic [7:0] CNT_LAST  = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    typedef struct packed {
        logic       ctrlValid;
        logic [2:0] aluOp;
        logic [2:0] regDst;
        logic [2:0] regSrc;
        logic [4:0] imm;
        logic       useImm;
        logic       regWe;
        logic       memRd;
        logic       memWr;
        logic       brEqz;
        logic       brNeqz;
        logic       jump;
        logic       call;
        logic       ret;
    } ctrl_t;

    state_t     state, stateNext;
    ctrl_t      ctrlQ, ctrlNext, decoded;
    logic [2:0] loadDstQ, loadDstNext;
    logic       isLoadQ, isLoadNext;
    logic [7:0] memCount, memCountNext;
    logic [3:0] depth, depthNext;
    logic       stackErrQ, stackErrNext;
    logic       memErrQ, memErrNext;

    // Decode the instruction currently on the input bus into a control word
    always_comb begin
        decoded = '0;
        decoded.ctrlValid = 1'b1;
        case (instr_i[8:5])
            4'b0000: begin
                decoded.aluOp  = instr_i[4] ? ALU_SUB : ALU_ADD;
                decoded.regDst = {1'b0, instr_i[3:2]};
                decoded.regSrc = {1'b0, instr_i[1:0]};
                decoded.regWe  = 1'b1;
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                decoded.regDst = {1'b0, instr_i[4:3]};
                decoded.imm    = {2'b00, instr_i[2:0]};
                decoded.useImm = 1'b1;
                decoded.regWe  = 1'b1;
                case (instr_i[8:5])
                    4'b0001: decoded.aluOp = ALU_ADD;
                    4'b0010: decoded.aluOp = ALU_SUB;
                    4'b0011: decoded.aluOp = ALU_SHR;
                    4'b0100: decoded.aluOp = ALU_SHL;
                    default: decoded.aluOp = ALU_AND;
                endcase
            end
            4'b0110, 4'b0111: begin
                // RSHL is the register-operand form of SHL
                decoded.aluOp  = instr_i[5] ? ALU_SHL : ALU_XOR;
                decoded.regDst = {1'b0, instr_i[4:3]};
                decoded.regSrc = {1'b0, instr_i[2:1]};
                decoded.regWe  = 1'b1;
            end
            4'b1000: begin
                decoded.aluOp  = ALU_PASS;
                decoded.regDst = {1'b0, instr_i[4:3]};
                decoded.regSrc = instr_i[2:0];
                decoded.regWe  = 1'b1;
            end
            4'b1001, 4'b1010: begin
                decoded.aluOp  = ALU_PASS;
                decoded.regSrc = {1'b0, instr_i[4:3]};
                decoded.imm    = {2'b00, instr_i[2:0]};
                decoded.brEqz  = (instr_i[8:5] == 4'b1001);
                decoded.brNeqz = (instr_i[8:5] == 4'b1010);
            end
            4'b1011: begin
                decoded.regDst = {1'b0, instr_i[3:2]};
                decoded.regSrc = {1'b0, instr_i[1:0]};
                decoded.memRd  = ~instr_i[4];
                decoded.memWr  = instr_i[4];
            end
            4'b1100: begin
                decoded.aluOp  = instr_i[4] ? ALU_OR : ALU_AND;
                decoded.regDst = {1'b0, instr_i[3:2]};
                decoded.regSrc = {1'b0, instr_i[1:0]};
                decoded.regWe  = 1'b1;
            end
            4'b1101, 4'b1110: begin
                decoded.aluOp = ALU_PASS;
                decoded.imm   = instr_i[4:0];
                decoded.jump  = (instr_i[8:5] == 4'b1101);
                decoded.call  = (instr_i[8:5] == 4'b1110);
            end
            default: decoded.ret = 1'b1;
        endcase
    end

    // Next state, next control word, call depth and sticky error flags
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        stateNext    = state;
        ctrlNext     = '0;
        loadDstNext  = loadDstQ;
        isLoadNext   = isLoadQ;
        memCountNext = memCount;
        depthNext    = depth;
        stackErrNext = stackErrQ;
        memErrNext   = memErrQ;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    ctrlNext    = decoded;
                    stateNext   = EXEC;
                    loadDstNext = decoded.regDst;
                    isLoadNext  = decoded.memRd;
                    if (decoded.call) begin
                        if (depth == DEPTH_MAX) stackErrNext = 1'b1;
                        else                    depthNext    = depth + 4'd1;
                    end
                    if (decoded.ret) begin
                        if (depth == 4'd0) stackErrNext = 1'b1;
                        else               depthNext    = depth - 4'd1;
                    end
                end
            end
            EXEC: begin
                memCountNext = '0;
                if (ctrlQ.memRd || ctrlQ.memWr) begin
                    stateNext      = MEM;
                    ctrlNext.memRd = ctrlQ.memRd;
                    ctrlNext.memWr = ctrlQ.memWr;
                end else begin
                    stateNext = IDLE;
                end
            end
            MEM: begin
                // An ack in the final timeout cycle still wins over the timeout
                if (mem_ack) begin
                    stateNext = IDLE;
                    if (isLoadQ) begin
                        ctrlNext.ctrlValid = 1'b1;
                        ctrlNext.regWe     = 1'b1;
                        ctrlNext.regDst    = loadDstQ;
                    end
                end else if (memCount == CNT_LAST) begin
                    stateNext  = IDLE;
                    memErrNext = 1'b1;
                end else begin
                    memCountNext   = memCount + 8'd1;
                    ctrlNext.memRd = ctrlQ.memRd;
                    ctrlNext.memWr = ctrlQ.memWr;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and registered control outputs, synchronous active-high reset
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (reset) begin
            state     <= IDLE;
            ctrlQ     <= '0;
            loadDstQ  <= '0;
            isLoadQ   <= 1'b0;
            memCount  <= '0;
            depth     <= '0;
            stackErrQ <= 1'b0;
            memErrQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            ctrlQ     <= ctrlNext;
            loadDstQ  <= loadDstNext;
            isLoadQ   <= isLoadNext;
            memCount  <= memCountNext;
            depth     <= depthNext;
            stackErrQ <= stackErrNext;
            memErrQ   <= memErrNext;
        end
    end

    assign instr_ready = (state == IDLE);
    assign ctrl_valid  = ctrlQ.ctrlValid;
    assign alu_op      = ctrlQ.aluOp;
    assign reg_dst     = ctrlQ.regDst;
    assign reg_src     = ctrlQ.regSrc;
    assign imm         = ctrlQ.imm;
    assign use_imm     = ctrlQ.useImm;
    assign reg_we      = ctrlQ.regWe;
    assign mem_rd      = ctrlQ.memRd;
    assign mem_wr      = ctrlQ.memWr;
    assign br_eqz      = ctrlQ.brEqz;
    assign br_neqz     = ctrlQ.brNeqz;
    assign jump        = ctrlQ.jump;
    assign call        = ctrlQ.call;
    assign ret         = ctrlQ.ret;
    assign stack_err   = stackErrQ;
    assign mem_err     = memErrQ;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// tb_instr_ctrl_fsm: directed and randomized checks of instr_ctrl_fsm against
// an instruction-level reference model (mnemonic table, field arithmetic,
// call-depth counter, memory handshake timing rules).
module tb_instr_ctrl_fsm;
    localparam int CALL_DEPTH  = 4;
    localparam int MEM_TIMEOUT = 15;

    logic       CLK = 1'b0;
    logic       reset;
    logic [8:0] instr_i;
    logic       instr_valid;
    logic       instr_ready;
    logic       mem_ack;
    logic       ctrl_valid;
    logic [2:0] alu_op;
    logic [2:0] reg_dst;
    logic [2:0] reg_src;
    logic [4:0] imm;
    logic       use_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       br_eqz;
    logic       br_neqz;
    logic       jump;
    logic       call;
    logic       ret;
    logic       stack_err;
    logic       mem_err;

    int checks   = 0;
    int failures = 0;

    int modelDepth;
    int modelStackErr;
    int modelMemErr;

    typedef struct {
        int valid; int alu; int dst; int src; int imm; int useImm; int we;
        int rd; int wr; int beq; int bne; int jmp; int cal; int rt;
    } word_t;

    instr_ctrl_fsm #(.CALL_DEPTH(CALL_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK(CLK), .reset(reset), .instr_i(instr_i), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .ctrl_valid(ctrl_valid),
        .alu_op(alu_op), .reg_dst(reg_dst), .reg_src(reg_src), .imm(imm),
        .use_imm(use_imm), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .br_eqz(br_eqz), .br_neqz(br_neqz), .jump(jump), .call(call), .ret(ret),
        .stack_err(stack_err), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and stop on the falling edge, where outputs are stable
    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic string mnemonic(input logic [8:0] ins);
        casez (ins[8:4])
            5'b00000: return "ADDR";
            5'b00001: return "SUBR";
            5'b0001?: return "ADDI";
            5'b0010?: return "SUBI";
            5'b0011?: return "SHR";
            5'b0100?: return "SHL";
            5'b0101?: return "ANDI";
            5'b0110?: return "XOR";
            5'b0111?: return "RSHL";
            5'b1000?: return "MOV";
            5'b1001?: return "BEQZ";
            5'b1010?: return "BNEQZ";
            5'b10110: return "LOAD";
            5'b10111: return "STORE";
            5'b11000: return "AND";
            5'b11001: return "OR";
            5'b1101?: return "J";
            5'b1110?: return "CALL";
            default:  return "RET";
        endcase
    endfunction

    function automatic int aluOf(input string m);
        case (m)
            "ADDR", "ADDI":                      return 0;
            "SUBR", "SUBI":                      return 1;
            "SHR":                               return 2;
            "SHL", "RSHL":                       return 3;
            "AND", "ANDI":                       return 4;
            "OR":                                return 5;
            "XOR":                               return 6;
            "MOV", "BEQZ", "BNEQZ", "J", "CALL": return 7;
            default:                             return 0;
        endcase
    endfunction

    function automatic word_t zeroWord();
        word_t z = '{default: 0};
        return z;
    endfunction

    // Expected EXEC-cycle control word, derived from the field rules
    function automatic word_t expectWord(input logic [8:0] ins);
        word_t e = '{default: 0};
        int v = int'(ins);
        string m = mnemonic(ins);
        e.valid = 1;
        e.alu   = aluOf(m);
        case (m)
            "ADDR", "SUBR", "AND", "OR", "LOAD", "STORE": begin
                e.dst = (v >> 2) % 4;
                e.src = v % 4;
                e.we  = (m != "LOAD" && m != "STORE") ? 1 : 0;
                e.rd  = (m == "LOAD") ? 1 : 0;
                e.wr  = (m == "STORE") ? 1 : 0;
            end
            "ADDI", "SUBI", "SHR", "SHL", "ANDI": begin
                e.dst = (v >> 3) % 4; e.imm = v % 8; e.useImm = 1; e.we = 1;
            end
            "XOR", "RSHL": begin
                e.dst = (v >> 3) % 4; e.src = (v >> 1) % 4; e.we = 1;
            end
            "MOV": begin
                e.dst = (v >> 3) % 4; e.src = v % 8; e.we = 1;
            end
            "BEQZ", "BNEQZ": begin
                e.src = (v >> 3) % 4; e.imm = v % 8;
                e.beq = (m == "BEQZ") ? 1 : 0;
                e.bne = (m == "BNEQZ") ? 1 : 0;
            end
            "J", "CALL": begin
                e.imm = v % 32;
                e.jmp = (m == "J") ? 1 : 0;
                e.cal = (m == "CALL") ? 1 : 0;
            end
            default: e.rt = 1;
        endcase
        return e;
    endfunction

    task automatic checkWord(input string tag, input word_t e);
        check({tag, ".ctrl_valid"}, ctrl_valid, e.valid);
        check({tag, ".alu_op"},     alu_op,     e.alu);
        check({tag, ".reg_dst"},    reg_dst,    e.dst);
        check({tag, ".reg_src"},    reg_src,    e.src);
        check({tag, ".imm"},        imm,        e.imm);
        check({tag, ".use_imm"},    use_imm,    e.useImm);
        check({tag, ".reg_we"},     reg_we,     e.we);
        check({tag, ".mem_rd"},     mem_rd,     e.rd);
        check({tag, ".mem_wr"},     mem_wr,     e.wr);
        check({tag, ".br_eqz"},     br_eqz,     e.beq);
        check({tag, ".br_neqz"},    br_neqz,    e.bne);
        check({tag, ".jump"},       jump,       e.jmp);
        check({tag, ".call"},       call,       e.cal);
        check({tag, ".ret"},        ret,        e.rt);
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".instr_ready"}, instr_ready, 1);
        check({tag, ".stack_err"},   stack_err,   modelStackErr);
        check({tag, ".mem_err"},     mem_err,     modelMemErr);
    endtask

    task automatic doReset();
        reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
        cycle();
        reset = 1'b0;
        modelDepth = 0; modelStackErr = 0; modelMemErr = 0;
        checkWord("reset", zeroWord());
        checkIdle("reset");
    endtask

    // Drive the memory handshake from the EXEC cycle of a LOAD/STORE;
    // ackAt is the MEM-cycle index in which mem_ack is raised (<0: never)
    task automatic runMem(input word_t e, input int ackAt);
        int    high = 1;
        bit    ended = 0;
        bit    acked;
        word_t p;
        check("mem.exec_ready", instr_ready, 0);
        mem_ack = 1'($urandom);
        cycle();
        mem_ack = 1'b0;
        for (int n = 0; n < MEM_TIMEOUT + 4 && !ended; n++) begin
            if ((e.rd != 0 ? mem_rd : mem_wr) === 1'b1) begin
                high++;
                check("mem.held_ctrl_valid", ctrl_valid, 0);
                check("mem.held_ready", instr_ready, 0);
                mem_ack     = (n == ackAt);
                instr_valid = 1'b1;
                instr_i     = 9'($urandom);
                cycle();
            end else begin
                ended = 1;
            end
        end
        mem_ack = 1'b0; instr_valid = 1'b0;
        check("mem.request_dropped", ended, 1);
        acked = (ackAt >= 0 && ackAt < MEM_TIMEOUT);
        check("mem.request_cycles", high, acked ? ackAt + 2 : MEM_TIMEOUT + 1);
        if (!acked) modelMemErr = 1;
        p = zeroWord();
        if (acked && e.rd != 0) begin
            p.valid = 1; p.we = 1; p.dst = e.dst;
        end
        checkWord("mem.done", p);
        checkIdle("mem.done");
    endtask

    // Present one instruction in IDLE and follow it back to IDLE
    task automatic issue(input logic [8:0] ins, input int ackAt);
        word_t e;
        string m;
        check("issue.ready", instr_ready, 1);
        instr_i = ins; instr_valid = 1'b1;
        cycle();
        instr_valid = 1'b0;
        e = expectWord(ins);
        m = mnemonic(ins);
        checkWord({"exec_", m}, e);
        if (m == "CALL") begin
            if (modelDepth == CALL_DEPTH) modelStackErr = 1; else modelDepth++;
        end
        if (m == "RET") begin
            if (modelDepth == 0) modelStackErr = 1; else modelDepth--;
        end
        if (e.rd != 0 || e.wr != 0) begin
            runMem(e, ackAt);
        end else begin
            check("exec.ready", instr_ready, 0);
            instr_valid = 1'b1; instr_i = 9'($urandom); mem_ack = 1'($urandom);
            cycle();
            instr_valid = 1'b0; mem_ack = 1'b0;
            checkWord({"after_", m}, zeroWord());
            checkIdle({"after_", m});
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_i = '0; mem_ack = 1'b0;
        cycle();
        doReset();

        // ALU register and immediate forms
        issue(9'b0_0000_0110, -1);
        issue(9'b0_0011_1101, -1);
        // LOAD acked in third MEM cycle: request high 4 cycles, one reg_we pulse
        issue(9'b1_0110_1000, 2);
        // LOAD acked in the final timeout cycle still counts as an ack
        issue(9'b1_0110_0100, MEM_TIMEOUT - 1);
        // LOAD acked one cycle too late times out
        issue(9'b1_0110_1100, MEM_TIMEOUT);
        // STORE with no ack times out, mem_err stays set
        issue(9'b1_0111_0101, -1);
        issue(9'b1_0111_0110, 0);
        check("mem_err.sticky", mem_err, 1);

        // Reset in the middle of a LOAD's MEM phase
        instr_i = 9'b1_0110_1000; instr_valid = 1'b1;
        cycle();
        instr_valid = 1'b0;
        check("midmem.exec_rd", mem_rd, 1);
        cycle(); cycle();
        check("midmem.held_rd", mem_rd, 1);
        doReset();
        check("midmem.rd_dropped", mem_rd, 0);

        // Call depth overflow on the fifth CALL
        for (int i = 0; i < CALL_DEPTH; i++) issue(9'b1_1100_0011, -1);
        check("call.no_err_at_full", stack_err, 0);
        issue(9'b1_1101_1110, -1);
        check("call.overflow_err", stack_err, 1);

        // RET underflow only after the stack has been fully unwound
        doReset();
        for (int i = 0; i < CALL_DEPTH; i++) issue(9'b1_1100_0001, -1);
        for (int i = 0; i < CALL_DEPTH; i++) issue(9'b1_1110_0000, -1);
        check("ret.no_err_at_empty", stack_err, 0);
        issue(9'b1_1111_0000, -1);
        check("ret.underflow_err", stack_err, 1);
        issue(9'b1_1110_1010, -1);

        // Randomized instruction stream with random ack timing and idle gaps
        doReset();
        for (int i = 0; i < 250; i++) begin
            logic [8:0] ins;
            int ackAt;
            ins = 9'($urandom);
            if ($urandom_range(0, 9) == 0) ackAt = -1;
            else ackAt = $urandom_range(0, MEM_TIMEOUT + 2);
            issue(ins, ackAt);
            repeat ($urandom_range(0, 2)) begin
                mem_ack = 1'($urandom);
                cycle();
            end
            mem_ack = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
